// File: rtl/clock_divider.sv
// Parameterised clock divider.
// Produces a 50% duty-cycle square wave at f(clk_in) / (2*COUNTER_MAX).
// A single wrap-around counter toggles the output flop on terminal count,
// so clk_out always comes straight from a register.
// clk_out is a fabric-generated clock: logic in other domains must treat it
// as asynchronous.
module clock_divider #(
  parameter int COUNTER_MAX = 1250000
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_out
);

  // Counter width is derived from COUNTER_MAX and must not be overridden.
  // COUNTER_MAX = 1 still needs one bit of counter.
  localparam int CNT_W = (COUNTER_MAX > 1) ? $clog2(COUNTER_MAX) : 1;

  // Terminal value. For a power of two this is all-ones at CNT_W bits,
  // so the wrap is always an explicit reload and never a natural overflow.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTER_MAX - 1);

  // Reject an illegal divide ratio at elaboration time.
  if (COUNTER_MAX < 1) begin : g_bad_counter_max
    $fatal(1, "clock_divider: COUNTER_MAX must be at least 1");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             clk_out_q, clk_out_d;

  // Next-state logic: count up to CNT_LAST, then reload 0 and flip the output.
  always_comb begin
    count_d   = count_q + CNT_W'(1);
    clk_out_d = clk_out_q;
    if (count_q == CNT_LAST) begin
      count_d   = '0;
      clk_out_d = ~clk_out_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      clk_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clock_divider.sv
// Testbench for clock_divider.
// Four instances (COUNTER_MAX = 4, 1, 8, 16) share one clock and reset.
// Expected outputs come from a closed-form model driven by the number of
// rising edges seen since reset release; they are queued when a clock edge
// is applied and popped/compared at the following falling edge.
module tb_clock_divider;

  typedef struct {
    logic out4;
    logic out1;
    logic out8;
    logic out16;
    int   cnt4;
    int   cnt8;
    int   cnt16;
  } expT;

  logic clock;
  logic reset;
  logic out4, out1, out8, out16;

  int   errors;
  int   checks;
  int   edgeCount;
  expT  sbQ[$];
  realtime riseQ[$];
  realtime fallQ[$];
  logic prevOut4;

  clock_divider #(.COUNTER_MAX(4))  dut4  (.clk_in(clock), .reset(reset), .clk_out(out4));
  clock_divider #(.COUNTER_MAX(1))  dut1  (.clk_in(clock), .reset(reset), .clk_out(out1));
  clock_divider #(.COUNTER_MAX(8))  dut8  (.clk_in(clock), .reset(reset), .clk_out(out8));
  clock_divider #(.COUNTER_MAX(16)) dut16 (.clk_in(clock), .reset(reset), .clk_out(out16));

  // 10 ns source clock, rising edges at 5, 15, 25 ns ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Closed-form model: after n edges out of reset the output is (n / M) mod 2
  // and the counter is n mod M.
  function automatic expT modelAt(int n);
    expT e;
    e.out4  = ((n / 4)  % 2) == 1;
    e.out1  = ((n / 1)  % 2) == 1;
    e.out8  = ((n / 8)  % 2) == 1;
    e.out16 = ((n / 16) % 2) == 1;
    e.cnt4  = n % 4;
    e.cnt8  = n % 8;
    e.cnt16 = n % 16;
    return e;
  endfunction

  // One comparison: count it, and report tag/observed/expected on failure.
  task automatic checkValue(string tag, int observed, int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Let one rising edge happen and queue what every instance should then show.
  task automatic applyStimulus();
    @(posedge clock);
    if (reset) edgeCount++;
    else       edgeCount = 0;
    sbQ.push_back(modelAt(edgeCount));
  endtask

  // At the falling edge, pop the oldest expectation and compare all instances.
  task automatic checkOutput();
    expT e;
    @(negedge clock);
    if (sbQ.size() == 0) begin
      checkValue("scoreboardEmpty", 0, 1);
      return;
    end
    e = sbQ.pop_front();
    checkValue("out4",  int'(out4),          int'(e.out4));
    checkValue("out1",  int'(out1),          int'(e.out1));
    checkValue("out8",  int'(out8),          int'(e.out8));
    checkValue("out16", int'(out16),         int'(e.out16));
    checkValue("cnt4",  int'(dut4.count_q),  e.cnt4);
    checkValue("cnt8",  int'(dut8.count_q),  e.cnt8);
    checkValue("cnt16", int'(dut16.count_q), e.cnt16);
    if (out4 === 1'b1 && prevOut4 === 1'b0) riseQ.push_back($realtime);
    if (out4 === 1'b0 && prevOut4 === 1'b1) fallQ.push_back($realtime);
    prevOut4 = out4;
  endtask

  task automatic runCycles(int count);
    for (int i = 0; i < count; i++) begin
      applyStimulus();
      checkOutput();
    end
  endtask

  // Everything asynchronous-reset related must read zero right now.
  task automatic checkAllZero(string tag);
    checkValue({tag, "_out4"},  int'(out4),          0);
    checkValue({tag, "_out1"},  int'(out1),          0);
    checkValue({tag, "_out8"},  int'(out8),          0);
    checkValue({tag, "_out16"}, int'(out16),         0);
    checkValue({tag, "_cnt4"},  int'(dut4.count_q),  0);
    checkValue({tag, "_cnt8"},  int'(dut8.count_q),  0);
    checkValue({tag, "_cnt16"}, int'(dut16.count_q), 0);
  endtask

  // Directed sequence.
  initial begin
    errors    = 0;
    checks    = 0;
    edgeCount = 0;
    prevOut4  = 1'b0;

    $display("[TB] power-up reset");
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 checkAllZero("resetNoClock");

    runCycles(2);

    $display("[TB] release reset, free run");
    reset     = 1'b1;
    edgeCount = 0;
    prevOut4  = 1'b0;
    riseQ.delete();
    fallQ.delete();
    runCycles(20);

    checkValue("rise4Seen", (riseQ.size() >= 2 && fallQ.size() >= 1) ? 1 : 0, 1);
    if (riseQ.size() >= 2 && fallQ.size() >= 1) begin
      checkValue("period4ns", int'(riseQ[1] - riseQ[0]), 80);
      checkValue("high4ns",   int'(fallQ[0] - riseQ[0]), 40);
    end

    runCycles(2);
    checkValue("preReset_out4", int'(out4),         1);
    checkValue("preReset_cnt4", int'(dut4.count_q), 2);

    $display("[TB] asynchronous reset mid-cycle");
    #2 reset = 1'b0;
    edgeCount = 0;
    #1 checkAllZero("resetMidCycle");

    runCycles(3);

    $display("[TB] release after mid-cycle reset");
    reset     = 1'b1;
    edgeCount = 0;
    prevOut4  = 1'b0;
    runCycles(36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
